gal_olmc_bank: RTL and testbench
================================

Name: gal_olmc_bank

Overview:
- Parametrised bank of GAL-style output logic macrocells.
- Each channel applies a runtime-selected 2-input function bitwise to buses a and b, with optional polarity inversion, and drives its output either combinationally or from a per-channel register.
- Channel configuration is loaded through a serial shift chain with a guarded commit.
- Successor to the fixed six-function combinational demo: width, channel count, function and mode are all configurable.

Parameters:
- CHANNELS, 6, number of macrocells.
- WIDTH, 2, bit width of a, b and each channel's output lane.
- CFG_BITS, 5, config bits per channel (fixed; not to be overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ce  input  1  clock enable for the output registers.
- clr  input  1  synchronous clear of all output registers.
- cfg_en  input  1  shift one config bit in this cycle.
- cfg_din  input  1  serial config data.
- cfg_commit  input  1  pulse: copy the shadow chain into the active config.
- cfg_ready  output  1  high when a full chain (CHANNELS*5 bits) has been shifted since the last reset or accepted commit.
- cfg_err  output  1  sticky; set by a rejected commit.
- m  output  CHANNELS*WIDTH  channel k drives m[k*WIDTH +: WIDTH].

Behaviour:
- Channel k config is active[5k+4:5k] = {inv, reg, op[2:0]}.
- Op codes, applied bitwise over WIDTH:
  - 0 = 0
  - 1 = a&b
  - 2 = a|b
  - 3 = a^b
  - 4 = ~(a&b)
  - 5 = ~(a|b)
  - 6 = ~a
  - 7 = q^a, where q is the channel's own register (toggle-on-a)
- d_k = f_k ^ {WIDTH{inv}}.
- Register q_k, priority order:
  - rst → 0;
  - else clr → 0;
  - else ce → q_k <= d_k;
  - else hold.
- q_k updates in both modes.
- Output: m_k = reg ? q_k : d_k.
  - Combinational mode: zero latency.
  - Registered mode: 1-cycle latency.
- Op 7 in combinational mode uses the current q_k. This is legal and defined: there is no combinational loop because q is registered.
- Shift chain: on cfg_en, shadow <= {shadow[CHANNELS*5-2:0], cfg_din}. The first bit sent lands at the MSB (channel CHANNELS-1 inv); the last bit sent is channel 0 op[0].
- Bit counter cnt counts 0..CHANNELS*5:
  - increments on cfg_en;
  - saturates at CHANNELS*5, and further shifts still move the chain;
  - cfg_ready = (cnt == CHANNELS*5).
- Commit:
  - If cfg_commit and cfg_ready: active <= shadow, cnt <= 0.
  - If cfg_commit and not cfg_ready: active unchanged, cfg_err <= 1, cnt unchanged.
- cfg_commit and cfg_en in the same cycle:
  - the commit uses the pre-shift shadow and pre-increment cnt;
  - the shift still occurs;
  - on an accepted commit, cnt becomes 1, since that cycle's bit counts toward the next load.
- New config is visible on m from the cycle after the commit. q is not cleared by a commit.
- cfg_err clears only on rst.
- Reset, asynchronous and usable mid-operation: active=0, shadow=0, cnt=0, q=0, cfg_err=0. Therefore m=0 and cfg_ready=0 immediately, with no clock required.

Test Plan (CHANNELS=6, WIDTH=2):
1. Assert rst asynchronously mid-cycle during a shift → m=0, cfg_ready=0, cfg_err=0 without a clock edge; after release, 30 bits are needed before cfg_ready=1.
2. Shift 30 bits configuring ch0..5 as comb XOR/NOR/NAND/AND/OR/NOT-A (inv=0, reg=0), then commit; apply a=2'b01, b=2'b11 → m lanes ch0..5 = 10,00,10,01,11,10.
3. Configure ch3 as registered AND, ce=1; step a,b from 00,00 to 11,11 at edge n → m ch3=00 until edge n+1, then 11. With ce=0, changing inputs hold 11. clr=1 together with ce=1 → 00 next edge.
4. Configure ch0 as reg=1, op=7, inv=0 from q=0; hold a=2'b11 for 3 edges → ch0 = 11, 00, 11. Then a=2'b01 → 10.
5. Shift 29 bits, commit → cfg_err=1, m unchanged. Shift 1 more bit and commit in the same cycle as a 31st cfg_en → accepted, cnt=1, cfg_err stays 1.
6. Configure ch5 as comb op 1 with inv=1 (NAND via polarity); a=2'b10, b=2'b10 → ch5=01. Confirm the change appears only the cycle after cfg_commit.

Source files
------------

// File: rtl/gal_olmc_bank.sv
// Bank of GAL-style output macrocells: per-channel 2-input function, polarity,
// and optional output register. Configuration is loaded through a serial shadow chain.
module gal_olmc_bank #(
    parameter int CHANNELS = 6,
    parameter int WIDTH    = 2,
    parameter int CFG_BITS = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
    input  logic                        ce,
    input  logic                        clr,
    input  logic                        cfg_en,
    input  logic                        cfg_din,
    input  logic                        cfg_commit,
    output logic                        cfg_ready,
    output logic                        cfg_err,
    output logic [CHANNELS*WIDTH-1:0]   m
);

    localparam int TOTAL = CHANNELS * CFG_BITS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);

    logic [TOTAL-1:0] shadow;
    logic [TOTAL-1:0] active;
    logic [CNT_W-1:0] cnt;

    assign cfg_ready = (cnt == CNT_FULL);

    // A commit sees the pre-shift shadow and count; a bit shifted in the same
    // cycle as an accepted commit is the first bit of the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            active  <= '0;
            cnt     <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (cfg_en) begin
                shadow <= {shadow[TOTAL-2:0], cfg_din};
            end
            if (cfg_commit && cfg_ready) begin
                active <= shadow;
                cnt    <= cfg_en ? CNT_W'(1) : '0;
            end else begin
                if (cfg_commit) begin
                    cfg_err <= 1'b1;
                end
                if (cfg_en && (cnt != CNT_FULL)) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic             inv;
        logic             is_reg;
        logic [2:0]       op;
        logic [WIDTH-1:0] f;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] q;

        assign {inv, is_reg, op} = active[k*CFG_BITS +: CFG_BITS];

        // Op 7 feeds back the registered q, so it never forms a combinational loop.
        always_comb begin
            f = '0;
            case (op)
                3'd0:    f = '0;
                3'd1:    f = a & b;
                3'd2:    f = a | b;
                3'd3:    f = a ^ b;
                3'd4:    f = ~(a & b);
                3'd5:    f = ~(a | b);
                3'd6:    f = ~a;
                default: f = q ^ a;
            endcase
        end

        assign d = f ^ {WIDTH{inv}};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= '0;
            end else if (clr) begin
                q <= '0;
            end else if (ce) begin
                q <= d;
            end
        end

        assign m[k*WIDTH +: WIDTH] = is_reg ? q : d;
    end

endmodule

// File: tb/tb_gal_olmc_bank.sv
// Scoreboard bench for gal_olmc_bank (CHANNELS=6, WIDTH=2): directed vectors push
// expected outputs into a queue; a monitor pops and compares them against the DUT.
module tb_gal_olmc_bank;

    localparam int CHANNELS = 6;
    localparam int WIDTH    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [WIDTH-1:0]          a;
    logic [WIDTH-1:0]          b;
    logic                      ce;
    logic                      clr;
    logic                      cfg_en;
    logic                      cfg_din;
    logic                      cfg_commit;
    logic                      cfg_ready;
    logic                      cfg_err;
    logic [CHANNELS*WIDTH-1:0] m;

    typedef struct {
        string       name;
        logic [11:0] m;
        logic        rdy;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   push_cnt = 0;
    int   pop_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;

    gal_olmc_bank #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .CFG_BITS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .ce         (ce),
        .clr        (clr),
        .cfg_en     (cfg_en),
        .cfg_din    (cfg_din),
        .cfg_commit (cfg_commit),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .m          (m)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] mk(input logic [4:0] c0, input logic [4:0] c1,
                                       input logic [4:0] c2, input logic [4:0] c3,
                                       input logic [4:0] c4, input logic [4:0] c5);
        return {c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic applyStimulus(input logic [1:0] av, input logic [1:0] bv,
                                 input logic cev, input logic clrv);
        @(negedge clk);
        a   = av;
        b   = bv;
        ce  = cev;
        clr = clrv;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] m_exp,
                               input logic rdy_exp, input logic err_exp);
        exp_t e;
        e.name = name;
        e.m    = m_exp;
        e.rdy  = rdy_exp;
        e.err  = err_exp;
        exp_q.push_back(e);
        push_cnt++;
        #1;
    endtask

    // Sends w[n-1] first down to w[0]; returns at a negedge with cfg_en low.
    task automatic shiftBits(input logic [29:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            cfg_en  = 1'b1;
            cfg_din = w[i];
        end
        @(negedge clk);
        cfg_en = 1'b0;
        #1;
    endtask

    task automatic commitPulse();
        @(negedge clk);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
        #1;
    endtask

    // Monitor: compares the DUT against each expectation as it is queued
    initial begin
        exp_t e;
        forever begin
            wait (pop_cnt < push_cnt);
            e = exp_q.pop_front();
            pop_cnt++;
            checks++;
            if (m !== e.m || cfg_ready !== e.rdy || cfg_err !== e.err) begin
                failures++;
                $display("[TB] FAIL %s: got m=%h ready=%b err=%b, expected m=%h ready=%b err=%b",
                         e.name, m, cfg_ready, cfg_err, e.m, e.rdy, e.err);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; a = '0; b = '0; ce = 1'b0; clr = 1'b0;
        cfg_en = 1'b0; cfg_din = 1'b0; cfg_commit = 1'b0;
        #3;
        checkOutput("reset_state", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Six comb functions: XOR, NOR, NAND, AND, OR, NOT-A
        applyStimulus(2'b01, 2'b11, 1'b0, 1'b0);
        shiftBits(mk(5'b00011, 5'b00101, 5'b00100, 5'b00001, 5'b00010, 5'b00110), 30);
        checkOutput("t2_ready_before_commit", 12'h000, 1'b1, 1'b0);
        commitPulse();
        checkOutput("t2_comb_lanes", 12'hB62, 1'b0, 1'b0);

        // ch3 registered AND
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        shiftBits(mk(5'b0, 5'b0, 5'b0, 5'b01001, 5'b0, 5'b0), 30);
        commitPulse();
        checkOutput("t3_start", 12'h000, 1'b0, 1'b0);
        applyStimulus(2'b00, 2'b00, 1'b1, 1'b0);
        applyStimulus(2'b11, 2'b11, 1'b1, 1'b0);
        checkOutput("t3_before_edge", 12'h000, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
        checkOutput("t3_registered", 12'h0C0, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
        checkOutput("t3_hold_ce0", 12'h0C0, 1'b0, 1'b0);
        applyStimulus(2'b11, 2'b11, 1'b1, 1'b1);
        checkOutput("t3_clr_before_edge", 12'h0C0, 1'b0, 1'b0);
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b0);
        checkOutput("t3_clr_over_ce", 12'h000, 1'b0, 1'b0);

        // ch0 registered toggle-on-a
        shiftBits(mk(5'b01111, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0), 30);
        commitPulse();
        checkOutput("t4_start", 12'h000, 1'b0, 1'b0);
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0);
        checkOutput("t4_pre", 12'h000, 1'b0, 1'b0);
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0);
        checkOutput("t4_toggle1", 12'h003, 1'b0, 1'b0);
        applyStimulus(2'b11, 2'b00, 1'b1, 1'b0);
        checkOutput("t4_toggle2", 12'h000, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0);
        checkOutput("t4_toggle3", 12'h003, 1'b0, 1'b0);
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
        checkOutput("t4_toggle_a01", 12'h002, 1'b0, 1'b0);

        // ch5 comb AND with inversion; new config appears only after the commit edge
        applyStimulus(2'b10, 2'b10, 1'b0, 1'b0);
        shiftBits(mk(5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b10001), 30);
        @(negedge clk);
        cfg_commit = 1'b1;
        #1;
        checkOutput("t6_commit_cycle_old", 12'h002, 1'b1, 1'b0);
        @(negedge clk);
        cfg_commit = 1'b0;
        #1;
        checkOutput("t6_after_commit", 12'h400, 1'b0, 1'b0);

        // Rejected commit, then accepted commit coinciding with a 31st shift
        shiftBits(mk(5'b0, 5'b00010, 5'b10110, 5'b0, 5'b0, 5'b0) >> 1, 29);
        checkOutput("t5_29_bits", 12'h400, 1'b0, 1'b0);
        commitPulse();
        checkOutput("t5_rejected", 12'h400, 1'b0, 1'b1);
        shiftBits(mk(5'b0, 5'b00010, 5'b10110, 5'b0, 5'b0, 5'b0), 1);
        checkOutput("t5_30_bits", 12'h400, 1'b1, 1'b1);
        @(negedge clk);
        cfg_en     = 1'b1;
        cfg_din    = 1'b1;
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_en     = 1'b0;
        cfg_commit = 1'b0;
        #1;
        checkOutput("t5_accepted", 12'h028, 1'b0, 1'b1);
        shiftBits(30'h2AAAAAAA, 28);
        checkOutput("t5_cnt_29", 12'h028, 1'b0, 1'b1);
        shiftBits(30'h0, 1);
        checkOutput("t5_cnt_30", 12'h028, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a shift cycle
        @(negedge clk);
        cfg_en  = 1'b1;
        cfg_din = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t1_async_reset", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        cfg_en = 1'b0;
        rst    = 1'b0;
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b0);
        shiftBits(30'h15555555, 29);
        checkOutput("t1_29_after_reset", 12'h000, 1'b0, 1'b0);
        shiftBits(30'h1, 1);
        checkOutput("t1_30_after_reset", 12'h000, 1'b1, 1'b0);

        #5;
        if (pop_cnt != push_cnt) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: popped=%0d pushed=%0d", pop_cnt, push_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
